// File: rtl/watch_link_pkg.sv
// rtl/watch_link_pkg.sv - shared types and constants for the watch link
package watch_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        SEND,
        WAIT,
        GAP
    } rd_state_t;

    localparam logic [7:0] DEFAULT_TERM = 8'h0A;

endpackage

// File: rtl/downlink_packetizer_fifo.sv
// rtl/downlink_packetizer_fifo.sv - byte fifo with registered read port
module downlink_packetizer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    // writes into a full fifo and reads from an empty one are silently ignored
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // storage array; contents need no reset because count guards every read
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // pointers, occupancy and the registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/downlink_packetizer.sv
// rtl/downlink_packetizer.sv - buffers received bytes and releases whole packets to the uart transmitter
module downlink_packetizer
    import watch_link_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 16,
    parameter logic [WIDTH-1:0] TERM       = DEFAULT_TERM,
    parameter int               GAP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_dv,
    input  logic [WIDTH-1:0] rx_byte,
    output logic             tx_dv,
    output logic [WIDTH-1:0] tx_byte,
    input  logic             tx_active,
    input  logic             tx_done,
    output logic             pkt_pending,
    output logic             busy,
    output logic             overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    rd_state_t        state;
    rd_state_t        state_next;
    logic [CW-1:0]    pkt_count;
    logic             flush_r;
    logic [GW-1:0]    gap_cnt;
    logic [WIDTH-1:0] tx_hold;
    logic [WIDTH-1:0] rd_data;
    logic             rd_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pkt_inc;
    logic             pkt_dec;
    logic             flush_clr;
    logic             last_byte;

    assign push    = rx_dv & ~fifo_full;
    assign pkt_inc = push & (rx_byte == TERM);

    downlink_packetizer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (~rst),
        .wr_en   (push),
        .wr_data (rx_byte),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // read-side next state; idle also requires the live count so a stale pending bit cannot start a partial packet
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        pkt_dec    = 1'b0;
        flush_clr  = 1'b0;
        last_byte  = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_pending && ((pkt_count != '0) || flush_r) && !tx_active) begin
                    state_next = POP;
                end
            end
            POP: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                end else begin
                    rd_en      = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (tx_hold == TERM) begin
                        pkt_dec   = 1'b1;
                        last_byte = 1'b1;
                    end else if (flush_r && fifo_empty) begin
                        flush_clr = 1'b1;
                        last_byte = 1'b1;
                    end
                    if (!last_byte) begin
                        state_next = POP;
                    end else if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // the start strobe and the byte come straight from the state so reset drops them at once
    assign tx_dv   = (state == SEND);
    assign tx_byte = (state == SEND) ? rd_data : tx_hold;
    assign busy    = (state != IDLE);

    // read fsm state, idle gap counter and the byte held for the transmitter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            tx_hold <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            if (state == SEND) begin
                tx_hold <= rd_data;
            end
        end
    end

    // packet accounting, forced-flush flag and the registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count   <= '0;
            flush_r     <= 1'b0;
            pkt_pending <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + CW'(1);
                2'b01:   pkt_count <= pkt_count - CW'(1);
                default: pkt_count <= pkt_count;
            endcase
            if (fifo_full && (pkt_count == '0)) begin
                flush_r <= 1'b1;
            end else if (flush_clr) begin
                flush_r <= 1'b0;
            end
            pkt_pending <= (pkt_count != '0) | flush_r;
            overflow    <= rx_dv & fifo_full;
        end
    end

endmodule

// File: tb/tb_downlink_packetizer.sv
// tb/tb_downlink_packetizer.sv - directed self-checking bench for downlink_packetizer
module tb_downlink_packetizer;

    typedef struct {
        logic [7:0] b;
        logic       ovf;
        logic [4:0] cnt;
        logic       flush;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_done = 1'b0;
    logic       tx_block = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_active;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       pkt_pending;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = 0;
    int pend_fall = 0;
    int busy_fall = 0;
    int ovf_cnt = 0;
    int d = 5;
    logic prev_busy = 1'b0;
    logic prev_pend = 1'b0;
    logic [7:0] resp_b;
    logic [7:0] cap_b[$];
    int         cap_c[$];
    vec_t       vec[21];
    logic [7:0] exp_b[$];

    assign tx_active = tx_block | tx_busy;

    always #5 clk = ~clk;

    downlink_packetizer #(
        .WIDTH      (8),
        .DEPTH      (16),
        .TERM       (8'h0A),
        .GAP_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_dv       (rx_dv),
        .rx_byte     (rx_byte),
        .tx_dv       (tx_dv),
        .tx_byte     (tx_byte),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .pkt_pending (pkt_pending),
        .busy        (busy),
        .overflow    (overflow)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done) done_cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        #1;
        if (tx_dv) begin
            cap_b.push_back(tx_byte);
            cap_c.push_back(cyc);
        end
        if (overflow) ovf_cnt++;
        if (prev_busy && !busy) busy_fall = cyc;
        if (prev_pend && !pkt_pending) pend_fall = cyc;
        prev_busy = busy;
        prev_pend = pkt_pending;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_dv) begin
                resp_b  = tx_byte;
                tx_busy = 1'b1;
                repeat (d) @(posedge clk);
                #1;
                if (busy) chk("tx_byte_held", tx_byte, resp_b);
                tx_done = 1'b1;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
                tx_busy = 1'b0;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_caps(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (cap_b.size() < n && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk(name, cap_b.size() >= n, 1);
    endtask

    task automatic clear_caps();
        cap_b.delete();
        cap_c.delete();
    endtask

    task automatic cmp_bytes(input string name);
        chk({name, "_count"}, cap_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i < cap_b.size()) chk($sformatf("%s_byte%0d", name, i), cap_b[i], exp_b[i]);
            else chk($sformatf("%s_byte%0d_missing", name, i), 0, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int s0;
        int k;

        vec[0] = '{8'h41, 1'b0, 5'd0, 1'b0};
        vec[1] = '{8'h0A, 1'b0, 5'd1, 1'b0};
        vec[2] = '{8'h42, 1'b0, 5'd1, 1'b0};
        vec[3] = '{8'h0A, 1'b0, 5'd2, 1'b0};
        for (int i = 0; i < 17; i++) begin
            vec[4 + i].b     = 8'(32 + i);
            vec[4 + i].ovf   = (i == 16);
            vec[4 + i].cnt   = 5'd0;
            vec[4 + i].flush = (i == 16);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("reset_tx_dv", tx_dv, 0);
        chk("reset_tx_byte", tx_byte, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pending", pkt_pending, 0);
        chk("reset_overflow", overflow, 0);
        rst = 1'b1;
        idle(2);

        d = 100;
        clear_caps();
        push(8'h41);
        push(8'h42);
        push(8'h0A);
        n0 = cyc;
        wait_caps(3, 1000, "single_timeout");
        idle(140);
        exp_b = '{8'h41, 8'h42, 8'h0A};
        cmp_bytes("single");
        if (cap_c.size() > 0) chk("single_latency", cap_c[0] - n0, 3);
        chk("single_pending_fall", pend_fall - done_cyc, 1);
        chk("single_busy_fall", busy_fall - done_cyc, 16);

        d = 5;
        clear_caps();
        push(8'h31);
        push(8'h32);
        idle(1000);
        chk("partial_no_tx", cap_b.size(), 0);
        chk("partial_pending", pkt_pending, 0);
        push(8'h0A);
        n0 = cyc;
        wait_caps(3, 200, "partial_timeout");
        idle(60);
        exp_b = '{8'h31, 8'h32, 8'h0A};
        cmp_bytes("partial");
        if (cap_c.size() > 0) chk("partial_latency", cap_c[0] - n0, 3);

        tx_block = 1'b1;
        clear_caps();
        for (int i = 0; i < 4; i++) begin
            push(vec[i].b);
            chk($sformatf("two_ovf%0d", i), overflow, vec[i].ovf);
            chk($sformatf("two_cnt%0d", i), dut.pkt_count, vec[i].cnt);
        end
        idle(2);
        chk("two_pending", pkt_pending, 1);
        tx_block = 1'b0;
        wait_caps(4, 500, "two_timeout");
        idle(60);
        exp_b = '{8'h41, 8'h0A, 8'h42, 8'h0A};
        cmp_bytes("two");
        if (cap_c.size() >= 4) begin
            chk("two_intra_gap0", cap_c[1] - cap_c[0], d + 2);
            chk("two_inter_gap", cap_c[2] - cap_c[1], d + 19);
            chk("two_intra_gap1", cap_c[3] - cap_c[2], d + 2);
        end
        chk("two_cnt_end", dut.pkt_count, 0);
        chk("two_pending_end", pkt_pending, 0);

        tx_block = 1'b1;
        clear_caps();
        ovf_cnt = 0;
        for (int i = 4; i < 21; i++) begin
            push(vec[i].b);
            chk($sformatf("ovf_pulse%0d", i - 4), overflow, vec[i].ovf);
            chk($sformatf("ovf_flush%0d", i - 4), dut.flush_r, vec[i].flush);
            chk($sformatf("ovf_cnt%0d", i - 4), dut.pkt_count, vec[i].cnt);
        end
        idle(3);
        chk("ovf_pulse_total", ovf_cnt, 1);
        chk("ovf_pending", pkt_pending, 1);
        tx_block = 1'b0;
        wait_caps(16, 800, "ovf_timeout");
        idle(40);
        exp_b.delete();
        for (int i = 0; i < 16; i++) exp_b.push_back(8'(32 + i));
        cmp_bytes("flush");
        chk("flush_pending_fall", pend_fall - done_cyc, 1);
        chk("flush_busy_fall", busy_fall - done_cyc, 16);
        chk("flush_cleared", dut.flush_r, 0);

        d = 20;
        clear_caps();
        push(8'h51);
        push(8'h52);
        push(8'h0A);
        wait_caps(1, 100, "sim_first_timeout");
        s0 = (cap_c.size() > 0) ? cap_c[0] : cyc;
        k = 0;
        while (cyc < s0 + d + 1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("sim_align", cyc, s0 + d + 1);
        push(8'h58);
        push(8'h59);
        push(8'h5A);
        push(8'h0A);
        wait_caps(7, 800, "sim_timeout");
        idle(60);
        exp_b = '{8'h51, 8'h52, 8'h0A, 8'h58, 8'h59, 8'h5A, 8'h0A};
        cmp_bytes("sim");
        if (cap_c.size() >= 4) chk("sim_gap", cap_c[3] - cap_c[2], d + 19);
        chk("sim_cnt_end", dut.pkt_count, 0);

        d = 30;
        clear_caps();
        push(8'h61);
        push(8'h62);
        push(8'h63);
        push(8'h0A);
        wait_caps(2, 200, "rst_timeout");
        idle(5);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_pending", pkt_pending, 0);
        chk("rst_busy", busy, 0);
        idle(3);
        rst = 1'b1;
        idle(200);
        chk("rst_no_tx", cap_b.size(), 2);
        push(8'h5A);
        push(8'h0A);
        wait_caps(4, 300, "rst_new_timeout");
        idle(80);
        exp_b = '{8'h61, 8'h62, 8'h5A, 8'h0A};
        cmp_bytes("rst_new");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
